// File: rtl/rotate_kick_engine.sv
// Sequential SRS rotator: tries each wall-kick candidate against an external
// collision checker and reports the first free pose.
module rotate_kick_engine #(
  parameter int COORD_W   = 6,
  parameter int NUM_KICKS = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic               i_clockwise,
  input  logic [2:0]         i_piece_type,
  input  logic [1:0]         i_rot_in,
  input  logic [COORD_W-1:0] i_x_in,
  input  logic [COORD_W-1:0] i_y_in,
  output logic               o_check_req,
  output logic [1:0]         o_cand_rot,
  output logic [COORD_W-1:0] o_cand_x,
  output logic [COORD_W-1:0] o_cand_y,
  input  logic               i_check_done,
  input  logic               i_check_hit,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_success,
  output logic [2:0]         o_kick_idx,
  output logic [1:0]         o_rot_out,
  output logic [COORD_W-1:0] o_x_out,
  output logic [COORD_W-1:0] o_y_out
);

  typedef enum logic [1:0] {S_IDLE, S_PROBE, S_WAIT, S_FIN} state_t;

  state_t             r_state;
  logic [2:0]         r_type;
  logic [1:0]         r_rot;
  logic [1:0]         r_tr;
  logic               r_cw;
  logic [2:0]         r_idx;
  logic [COORD_W-1:0] r_x;
  logic [COORD_W-1:0] r_y;

  logic [1:0]         w_in_tr;
  logic [2:0]         w_nidx;
  logic [2:0]         w_limit;
  logic signed [3:0]  w_ax, w_ay, w_bx, w_by, w_cx, w_cy;
  logic signed [3:0]  w_dx, w_dy, w_ox, w_oy;
  logic               w_sx, w_sy, w_use_c;
  logic [COORD_W-1:0] w_next_x, w_next_y;

  assign w_in_tr = i_clockwise ? i_rot_in + 2'd1 : i_rot_in - 2'd1;
  assign w_nidx  = r_idx + 3'd1;
  assign w_limit = (r_type == 3'd1) ? 3'd1 : 3'(NUM_KICKS);

  // Base tables in y-up convention; entry 0 is always (0,0).
  always_comb begin
    w_ax = 4'sd0; w_ay = 4'sd0;
    w_bx = 4'sd0; w_by = 4'sd0;
    w_cx = 4'sd0; w_cy = 4'sd0;
    case (w_nidx)
      3'd1: begin w_ax = -4'sd1; w_bx = -4'sd2; w_cx = -4'sd1; end
      3'd2: begin w_ax = -4'sd1; w_ay =  4'sd1; w_bx =  4'sd1; w_cx = 4'sd2; end
      3'd3: begin w_ay = -4'sd2; w_bx = -4'sd2; w_by = -4'sd1; w_cx = -4'sd1; w_cy = 4'sd2; end
      3'd4: begin
        w_ax = -4'sd1; w_ay = -4'sd2;
        w_bx =  4'sd1; w_by =  4'sd2;
        w_cx =  4'sd2; w_cy = -4'sd1;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_use_c = 1'b0;
    w_sx    = 1'b0;
    w_sy    = 1'b0;
    w_dx    = w_ax;
    w_dy    = w_ay;
    if (r_type == 3'd0) begin
      case ({r_rot, r_cw})
        3'b000, 3'b011: begin w_use_c = 1'b1; end
        3'b100, 3'b111: begin w_use_c = 1'b1; w_sx = 1'b1; w_sy = 1'b1; end
        3'b010, 3'b101: begin w_sx = 1'b1; w_sy = 1'b1; end
        default: ;
      endcase
      w_dx = w_use_c ? w_cx : w_bx;
      w_dy = w_use_c ? w_cy : w_by;
    end else if (r_tr == 2'd1) begin
      w_sx = 1'b0;
    end else if (r_rot == 2'd1) begin
      w_sx = 1'b1; w_sy = 1'b1;
    end else if (r_tr == 2'd3) begin
      w_sx = 1'b1;
    end else begin
      w_sy = 1'b1;
    end
  end

  // Screen y grows downward, so the y-up offset is subtracted.
  assign w_ox     = w_sx ? -w_dx : w_dx;
  assign w_oy     = w_sy ? -w_dy : w_dy;
  assign w_next_x = r_x + COORD_W'(w_ox);
  assign w_next_y = r_y - COORD_W'(w_oy);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_type      <= '0;
      r_rot       <= '0;
      r_tr        <= '0;
      r_cw        <= 1'b0;
      r_idx       <= '0;
      r_x         <= '0;
      r_y         <= '0;
      o_check_req <= 1'b0;
      o_cand_rot  <= '0;
      o_cand_x    <= '0;
      o_cand_y    <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_success   <= 1'b0;
      o_kick_idx  <= '0;
      o_rot_out   <= '0;
      o_x_out     <= '0;
      o_y_out     <= '0;
    end else begin
      o_check_req <= 1'b0;
      o_done      <= 1'b0;
      case (r_state)
        S_IDLE, S_FIN: begin
          r_state <= S_IDLE;
          if (i_start) begin
            r_type      <= i_piece_type;
            r_rot       <= i_rot_in;
            r_tr        <= w_in_tr;
            r_cw        <= i_clockwise;
            r_x         <= i_x_in;
            r_y         <= i_y_in;
            r_idx       <= '0;
            o_cand_rot  <= w_in_tr;
            o_cand_x    <= i_x_in;
            o_cand_y    <= i_y_in;
            o_check_req <= 1'b1;
            o_busy      <= 1'b1;
            o_success   <= 1'b0;
            o_kick_idx  <= '0;
            r_state     <= S_PROBE;
          end
        end
        S_PROBE: r_state <= S_WAIT;
        S_WAIT: begin
          if (i_check_done) begin
            if (!i_check_hit) begin
              o_success  <= 1'b1;
              o_kick_idx <= r_idx;
              o_rot_out  <= o_cand_rot;
              o_x_out    <= o_cand_x;
              o_y_out    <= o_cand_y;
              o_done     <= 1'b1;
              o_busy     <= 1'b0;
              r_state    <= S_FIN;
            end else if (w_nidx < w_limit) begin
              r_idx       <= w_nidx;
              o_cand_x    <= w_next_x;
              o_cand_y    <= w_next_y;
              o_check_req <= 1'b1;
              r_state     <= S_PROBE;
            end else begin
              o_success  <= 1'b0;
              o_kick_idx <= '0;
              o_rot_out  <= r_rot;
              o_x_out    <= r_x;
              o_y_out    <= r_y;
              o_done     <= 1'b1;
              o_busy     <= 1'b0;
              r_state    <= S_FIN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
